memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/memory_access.sv | 112 +++++++++++
 tb/tb_memory_access.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg : opcodes and memory-stage FSM encoding shared by MA/WB |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package pipeline_pkg;

  localparam logic [4:0] c_OP_LOAD  = 5'b01100;
  localparam logic [4:0] c_OP_LOADI = 5'b01101;
  localparam logic [4:0] c_OP_STORE = 5'b01110;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_WAIT = 1'b1;

  localparam logic [3:0] c_WAIT_LIMIT = 4'd15;

  function automatic logic is_load_op(input logic [4:0] i_op);
    return (i_op == c_OP_LOAD) || (i_op == c_OP_LOADI);
  endfunction

  function automatic logic is_mem_op(input logic [4:0] i_op);
    return is_load_op(i_op) || (i_op == c_OP_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_access : pipeline MA stage, single outstanding data request   |
// | with 15-cycle timeout.                              Revision 1.0     |
// +----------------------------------------------------------------------+
module memory_access
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID_EX,
  input  logic [4:0]  DEST_REG_INDEX_EX,
  input  logic        DEST_REG_WRITE_EN_EX,
  input  logic [15:0] RES_EX,
  input  logic [15:0] STORE_DATA_EX,
  input  logic [4:0]  CTRL_EX,
  output logic        STALL_MA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [4:0]  DEST_REG_INDEX_MA,
  output logic        DEST_REG_WRITE_EN_MA,
  output logic [15:0] RES_MA,
  output logic [15:0] DATA_MA,
  output logic [4:0]  CTRL_MA,
  output logic        MEM_ERR
);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_cap_idx;
  logic        r_cap_wen;
  logic [15:0] r_cap_res;
  logic [4:0]  r_cap_ctrl;

  logic w_accept;
  logic w_mem_op;

  assign STALL_MA = (r_state == c_ST_WAIT);
  assign w_accept = VALID_EX & ~STALL_MA;
  assign w_mem_op = is_mem_op(CTRL_EX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= c_ST_IDLE;
      r_cnt                <= 4'd0;
      r_cap_idx            <= 5'd0;
      r_cap_wen            <= 1'b0;
      r_cap_res            <= 16'd0;
      r_cap_ctrl           <= 5'd0;
      MEM_REQ              <= 1'b0;
      MEM_WE               <= 1'b0;
      MEM_ADDR             <= 16'd0;
      MEM_WDATA            <= 16'd0;
      DEST_REG_INDEX_MA    <= 5'd0;
      DEST_REG_WRITE_EN_MA <= 1'b0;
      RES_MA               <= 16'd0;
      DATA_MA              <= 16'd0;
      CTRL_MA              <= 5'd0;
      MEM_ERR              <= 1'b0;
    end else if (r_state == c_ST_IDLE) begin
      if (w_accept && w_mem_op) begin
        // Hold the instruction aside; *_MA keep their old values while WAIT.
        r_state              <= c_ST_WAIT;
        r_cnt                <= 4'd0;
        r_cap_idx            <= DEST_REG_INDEX_EX;
        r_cap_wen            <= DEST_REG_WRITE_EN_EX;
        r_cap_res            <= RES_EX;
        r_cap_ctrl           <= CTRL_EX;
        MEM_REQ              <= 1'b1;
        MEM_WE               <= (CTRL_EX == c_OP_STORE);
        MEM_ADDR             <= RES_EX;
        MEM_WDATA            <= STORE_DATA_EX;
        DEST_REG_WRITE_EN_MA <= 1'b0;
      end else if (w_accept) begin
        DEST_REG_INDEX_MA    <= DEST_REG_INDEX_EX;
        DEST_REG_WRITE_EN_MA <= DEST_REG_WRITE_EN_EX;
        RES_MA               <= RES_EX;
        DATA_MA              <= 16'd0;
        CTRL_MA              <= CTRL_EX;
      end else begin
        DEST_REG_WRITE_EN_MA <= 1'b0;
      end
    end else begin
      if (MEM_ACK) begin
        r_state              <= c_ST_IDLE;
        MEM_REQ              <= 1'b0;
        MEM_WE               <= 1'b0;
        DEST_REG_INDEX_MA    <= r_cap_idx;
        DEST_REG_WRITE_EN_MA <= r_cap_wen & (r_cap_ctrl != c_OP_STORE);
        RES_MA               <= r_cap_res;
        DATA_MA              <= is_load_op(r_cap_ctrl) ? MEM_RDATA : 16'd0;
        CTRL_MA              <= r_cap_ctrl;
      end else if (r_cnt == (c_WAIT_LIMIT - 4'd1)) begin
        // Fifteenth silent cycle: give up, counter parks at the limit.
        r_state              <= c_ST_IDLE;
        r_cnt                <= c_WAIT_LIMIT;
        MEM_REQ              <= 1'b0;
        MEM_WE               <= 1'b0;
        DEST_REG_WRITE_EN_MA <= 1'b0;
        MEM_ERR              <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_access : directed and random bench with reference model    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_memory_access;

  localparam logic [4:0] LOAD  = 5'b01100;
  localparam logic [4:0] LOADI = 5'b01101;
  localparam logic [4:0] STORE = 5'b01110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        VALID_EX = 1'b0;
  logic [4:0]  DEST_REG_INDEX_EX = '0;
  logic        DEST_REG_WRITE_EN_EX = 1'b0;
  logic [15:0] RES_EX = '0;
  logic [15:0] STORE_DATA_EX = '0;
  logic [4:0]  CTRL_EX = '0;
  logic [15:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;
  logic        STALL_MA, MEM_REQ, MEM_WE, MEM_ERR, DEST_REG_WRITE_EN_MA;
  logic [15:0] MEM_ADDR, MEM_WDATA, RES_MA, DATA_MA;
  logic [4:0]  DEST_REG_INDEX_MA, CTRL_MA;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .VALID_EX(VALID_EX),
    .DEST_REG_INDEX_EX(DEST_REG_INDEX_EX), .DEST_REG_WRITE_EN_EX(DEST_REG_WRITE_EN_EX),
    .RES_EX(RES_EX), .STORE_DATA_EX(STORE_DATA_EX), .CTRL_EX(CTRL_EX),
    .STALL_MA(STALL_MA), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .DEST_REG_INDEX_MA(DEST_REG_INDEX_MA), .DEST_REG_WRITE_EN_MA(DEST_REG_WRITE_EN_MA),
    .RES_MA(RES_MA), .DATA_MA(DATA_MA), .CTRL_MA(CTRL_MA), .MEM_ERR(MEM_ERR)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: one outstanding request, count of silent cycles.
  bit          m_busy;
  int          m_waits;
  int          lat;
  logic        m_req, m_we, m_wen, m_err;
  logic [15:0] m_addr, m_wdata, m_res, m_data;
  logic [4:0]  m_idx, m_ctrl;
  logic [4:0]  p_idx, p_ctrl;
  logic        p_wen;
  logic [15:0] p_res;

  function automatic bit is_load(input logic [4:0] op);
    return (op == LOAD) || (op == LOADI);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waits = 0; m_req = 0; m_we = 0; m_wen = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_res = 0; m_data = 0; m_idx = 0; m_ctrl = 0;
    p_idx = 0; p_ctrl = 0; p_wen = 0; p_res = 0;
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (VALID_EX && (is_load(CTRL_EX) || CTRL_EX == STORE)) begin
        m_busy = 1; m_waits = 0; lat = $urandom_range(1, 17);
        m_req = 1; m_we = (CTRL_EX == STORE); m_addr = RES_EX; m_wdata = STORE_DATA_EX;
        m_wen = 0;
        p_idx = DEST_REG_INDEX_EX; p_wen = DEST_REG_WRITE_EN_EX; p_res = RES_EX; p_ctrl = CTRL_EX;
      end else if (VALID_EX) begin
        m_idx = DEST_REG_INDEX_EX; m_wen = DEST_REG_WRITE_EN_EX; m_res = RES_EX;
        m_data = 0; m_ctrl = CTRL_EX;
      end else begin
        m_wen = 0;
      end
    end else if (MEM_ACK) begin
      m_busy = 0; m_req = 0; m_we = 0;
      m_idx = p_idx; m_res = p_res; m_ctrl = p_ctrl;
      m_data = is_load(p_ctrl) ? MEM_RDATA : 16'd0;
      m_wen = (p_ctrl == STORE) ? 1'b0 : p_wen;
    end else begin
      m_waits++;
      if (m_waits == 15) begin
        m_busy = 0; m_req = 0; m_we = 0; m_wen = 0; m_err = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("STALL_MA", {15'd0, STALL_MA}, {15'd0, m_busy});
    chk("MEM_REQ", {15'd0, MEM_REQ}, {15'd0, m_req});
    chk("MEM_WE", {15'd0, MEM_WE}, {15'd0, m_we});
    chk("MEM_ADDR", MEM_ADDR, m_addr);
    chk("MEM_WDATA", MEM_WDATA, m_wdata);
    chk("DEST_IDX_MA", {11'd0, DEST_REG_INDEX_MA}, {11'd0, m_idx});
    chk("WEN_MA", {15'd0, DEST_REG_WRITE_EN_MA}, {15'd0, m_wen});
    chk("RES_MA", RES_MA, m_res);
    chk("DATA_MA", DATA_MA, m_data);
    chk("CTRL_MA", {11'd0, CTRL_MA}, {11'd0, m_ctrl});
    chk("MEM_ERR", {15'd0, MEM_ERR}, {15'd0, m_err});
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_instr(input logic v, input logic [4:0] op, input logic [15:0] res,
                           input logic [15:0] sd, input logic [4:0] idx, input logic wen);
    VALID_EX = v; CTRL_EX = op; RES_EX = res; STORE_DATA_EX = sd;
    DEST_REG_INDEX_EX = idx; DEST_REG_WRITE_EN_EX = wen;
  endtask

  task automatic drive_random();
    logic [4:0] op;
    if (!m_busy) begin
      case ($urandom_range(0, 3))
        0: op = LOAD;
        1: op = LOADI;
        2: op = STORE;
        default: op = 5'($urandom);
      endcase
      set_instr(($urandom_range(0, 3) != 0), op, 16'($urandom), 16'($urandom),
                5'($urandom), 1'($urandom));
      MEM_ACK = ($urandom_range(0, 3) == 0);
    end else begin
      MEM_ACK = ((m_waits + 1) == lat);
    end
    MEM_RDATA = 16'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_req", {15'd0, MEM_REQ}, 16'd0);
    rst_n = 1'b1;

    // ADD-class instruction passes straight through
    set_instr(1, 5'd0, 16'h1234, 16'h0, 5'd3, 1);
    cycle();
    chk("add_res", RES_MA, 16'h1234);
    chk("add_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd1);
    chk("add_stall", {15'd0, STALL_MA}, 16'd0);
    VALID_EX = 0;
    cycle();
    chk("bubble_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd0);

    // LOAD acked in the third request cycle
    set_instr(1, LOAD, 16'h0040, 16'h0, 5'd7, 1);
    cycle();
    chk("load_req", {15'd0, MEM_REQ}, 16'd1);
    chk("load_addr", MEM_ADDR, 16'h0040);
    chk("load_stall", {15'd0, STALL_MA}, 16'd1);
    VALID_EX = 0;
    cycle();
    cycle();
    chk("load_req3", {15'd0, MEM_REQ}, 16'd1);
    chk("load_wen_wait", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd0);
    MEM_ACK = 1; MEM_RDATA = 16'hBEEF;
    cycle();
    chk("load_done_req", {15'd0, MEM_REQ}, 16'd0);
    chk("load_data", DATA_MA, 16'hBEEF);
    chk("load_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd1);
    MEM_ACK = 0;
    cycle();
    chk("load_wen_once", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd0);

    // STORE never writes the register file
    set_instr(1, STORE, 16'h0010, 16'h00AA, 5'd9, 1);
    cycle();
    chk("store_we", {15'd0, MEM_WE}, 16'd1);
    chk("store_wdata", MEM_WDATA, 16'h00AA);
    VALID_EX = 0; MEM_ACK = 1;
    cycle();
    chk("store_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd0);
    MEM_ACK = 0;

    // ACK on the fifteenth wait cycle completes normally
    set_instr(1, LOADI, 16'h0100, 16'h0, 5'd4, 1);
    cycle();
    VALID_EX = 0;
    repeat (14) cycle();
    MEM_ACK = 1; MEM_RDATA = 16'h5A5A;
    cycle();
    chk("ack15_err", {15'd0, MEM_ERR}, 16'd0);
    chk("ack15_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd1);
    chk("ack15_data", DATA_MA, 16'h5A5A);
    MEM_ACK = 0;

    // No ACK: timeout after fifteen wait cycles
    set_instr(1, LOAD, 16'h0200, 16'h0, 5'd5, 1);
    cycle();
    VALID_EX = 0;
    repeat (14) cycle();
    chk("abort_req14", {15'd0, MEM_REQ}, 16'd1);
    cycle();
    chk("abort_req", {15'd0, MEM_REQ}, 16'd0);
    chk("abort_err", {15'd0, MEM_ERR}, 16'd1);
    chk("abort_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd0);
    repeat (3) cycle();
    chk("err_sticky", {15'd0, MEM_ERR}, 16'd1);

    // Asynchronous reset in the middle of WAIT, then a late ACK
    set_instr(1, LOAD, 16'h0300, 16'h0, 5'd6, 1);
    cycle();
    VALID_EX = 0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", {15'd0, MEM_REQ}, 16'd0);
    chk("rst_stall", {15'd0, STALL_MA}, 16'd0);
    chk("rst_res", RES_MA, 16'h0);
    chk("rst_err", {15'd0, MEM_ERR}, 16'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1; MEM_ACK = 1; MEM_RDATA = 16'hDEAD;
    cycle();
    chk("late_ack_wen", {15'd0, DEST_REG_WRITE_EN_MA}, 16'd0);
    chk("late_ack_data", DATA_MA, 16'h0);
    MEM_ACK = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
